// File: rtl/instruction_loader_pkg.sv
// Purpose: shared FSM state type and sizing defaults for the instruction loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instruction_loader_pkg;

  localparam int DEPTH_DEF  = 64;
  localparam int ADDR_W_DEF = 6;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Purpose: packs a little-endian byte stream into 32-bit words.
// Latency: combinational word_o, valid in the cycle the last byte is accepted.
// Backpressure: none of its own; accepts whenever accept_i is high.
// Ports: clk/reset; clear_i restarts at byte 0; accept_i + byte_i shift a byte in;
//        word_o is the word that includes byte_i; last_o flags the final byte of a word.
module word_assembler
  import instruction_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        last_o
);

  // Only the first three bytes need storage; the fourth comes straight from byte_i.
  logic [23:0] sh_q;
  logic [1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (accept_i) begin
      sh_q  <= {byte_i, sh_q[23:8]};
      cnt_q <= cnt_q + 2'd1;  // wraps to 0 after the last byte of a word
    end
  end

  assign word_o = {byte_i, sh_q};
  assign last_o = (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/instruction_loader.sv
// Purpose: streams bytes into 32-bit words and writes them to an external instruction memory.
// Latency: mem_we rises 1 cycle after the 4th byte handshake; 5 cycles per word back-to-back.
// Backpressure: byte_ready high only in LOAD; low during WRITE/DONE/IDLE.
// Ports: start/word_count open a session; byte_in/byte_valid/byte_ready carry bytes;
//        mem_we/mem_addr/mem_wdata drive the memory; busy/done/error/checksum report status.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W:0]     count_q;
  logic                byte_ready_q, mem_we_q, busy_q, done_q, error_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q, checksum_q;

  logic        legal_count, start_ok, accept, last_word, asm_last;
  logic [31:0] asm_word;

  assign legal_count = (word_count != '0) && (word_count <= DEPTH_C);
  assign start_ok    = (state_q == IDLE) && start && legal_count;
  // byte_ready_q is only ever set while in LOAD, so it alone qualifies the handshake.
  assign accept      = byte_valid && byte_ready_q;
  assign last_word   = ({1'b0, idx_q} == (count_q - 1'b1));

  word_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (start_ok),
    .accept_i (accept),
    .byte_i   (byte_in),
    .word_o   (asm_word),
    .last_o   (asm_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      checksum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (legal_count) begin
              state_q      <= LOAD;
              idx_q        <= '0;
              count_q      <= word_count;
              checksum_q   <= '0;
              error_q      <= 1'b0;
              byte_ready_q <= 1'b1;
              busy_q       <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept && asm_last) begin
            state_q      <= WRITE;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b1;
            mem_addr_q   <= idx_q;
            mem_wdata_q  <= asm_word;
          end
        end
        WRITE: begin
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          checksum_q  <= checksum_q + mem_wdata_q;
          // count_q <= DEPTH, so the index tops out at DEPTH-1 and never wraps.
          if (last_word) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q        <= idx_q + 1'b1;
            state_q      <= LOAD;
            byte_ready_q <= 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Purpose: directed scoreboard bench for instruction_loader.
// Latency: n/a.
// Backpressure: drives byte_valid with optional idle gaps between bytes.
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  word_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready, mem_we, busy, done, error;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, checksum;

  always #5 clk = ~clk;

  instruction_loader #(.DEPTH(64), .ADDR_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .checksum   (checksum)
  );

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [31:0] exp_sum[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          chk_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each write/done and checks write timing.
  initial begin
    int  nb = 0;
    bit  exp_we = 1'b0;
    wr_t w;
    forever begin
      @(negedge clk);
      chk("we_timing", {31'd0, mem_we}, {31'd0, exp_we});
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write_addr", {26'd0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          w = exp_wr.pop_front();
          chk("write_addr", {26'd0, mem_addr}, {26'd0, w.addr});
          chk("write_data", mem_wdata, w.data);
        end
      end else begin
        chk("idle_addr_zero", {26'd0, mem_addr}, 32'd0);
        chk("idle_wdata_zero", mem_wdata, 32'd0);
      end
      if (done) begin
        if (exp_sum.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else chk("done_checksum", checksum, exp_sum.pop_front());
      end
      if (reset) begin
        nb = 0;
        exp_we = 1'b0;
      end else if (byte_valid && byte_ready) begin
        nb++;
        exp_we = (nb % 4 == 0);
      end else begin
        exp_we = 1'b0;
      end
    end
  end

  task automatic do_start(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    word_count = 7'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    bit acc = 1'b0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!acc && t < 100) begin
      @(negedge clk);
      acc = byte_ready;
      if (chk_busy) chk("busy_in_session", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      t++;
    end
    byte_valid = 1'b0;
    if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) begin
      if (gap) begin
        @(posedge clk); #1;
      end
      push_byte(w[8*k +: 8]);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    bit seen = 1'b0;
    while (!seen && t < 200) begin
      @(negedge clk);
      seen = done;
      t++;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    chk({tag, "_checksum"}, checksum, 32'd0);
  endtask

  initial begin
    logic [31:0] wd;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Single word, back-to-back bytes
    exp_wr.push_back('{6'd0, 32'h0050_0013});
    exp_sum.push_back(32'h0050_0013);
    do_start(1);
    send_word(32'h0050_0013, 1'b0);
    wait_done();
    chk("checksum_hold", checksum, 32'h0050_0013);
    chk("busy_after_done", {31'd0, busy}, 32'd0);

    // Three words, byte_valid low every other cycle
    exp_wr.push_back('{6'd0, 32'h1122_3344});
    exp_wr.push_back('{6'd1, 32'hA5A5_0001});
    exp_wr.push_back('{6'd2, 32'hDEAD_BEEF});
    exp_sum.push_back(32'h9574_F234);
    do_start(3);
    chk_busy = 1'b1;
    send_word(32'h1122_3344, 1'b1);
    send_word(32'hA5A5_0001, 1'b1);
    send_word(32'hDEAD_BEEF, 1'b1);
    chk_busy = 1'b0;
    wait_done();

    // Illegal counts, then a legal start clears error
    do_start(0);
    @(negedge clk);
    chk("err_cnt0", {31'd0, error}, 32'd1);
    chk("err_cnt0_busy", {31'd0, busy}, 32'd0);
    chk("err_cnt0_ready", {31'd0, byte_ready}, 32'd0);
    do_start(65);
    @(negedge clk);
    chk("err_cnt65", {31'd0, error}, 32'd1);
    chk("err_cnt65_busy", {31'd0, busy}, 32'd0);
    exp_wr.push_back('{6'd0, 32'h0000_0001});
    exp_sum.push_back(32'h0000_0001);
    do_start(1);
    chk("err_cleared", {31'd0, error}, 32'd0);
    chk("busy_after_legal", {31'd0, busy}, 32'd1);
    send_word(32'h0000_0001, 1'b0);
    wait_done();

    // Full depth, all ones
    for (int i = 0; i < 64; i++) exp_wr.push_back('{6'(i), 32'hFFFF_FFFF});
    exp_sum.push_back(32'hFFFF_FFC0);
    do_start(64);
    for (int i = 0; i < 64; i++) send_word(32'hFFFF_FFFF, 1'b0);
    wait_done();
    chk("full_checksum_hold", checksum, 32'hFFFF_FFC0);

    // Reset mid-word, then a clean restart
    exp_wr.push_back('{6'd0, 32'h0403_0201});
    do_start(4);
    send_word(32'h0403_0201, 1'b0);
    wd = 32'h0807_0605;
    push_byte(wd[7:0]);
    push_byte(wd[15:8]);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midreset_queue_empty", exp_wr.size(), 32'd0);
    exp_wr.push_back('{6'd0, 32'hCAFE_F00D});
    exp_sum.push_back(32'hCAFE_F00D);
    do_start(1);
    send_word(32'hCAFE_F00D, 1'b0);
    wait_done();

    // start pulsed during LOAD is ignored
    exp_wr.push_back('{6'd0, 32'h8765_4321});
    exp_wr.push_back('{6'd1, 32'h0000_00FF});
    exp_sum.push_back(32'h8765_4420);
    do_start(2);
    wd = 32'h8765_4321;
    push_byte(wd[7:0]);
    push_byte(wd[15:8]);
    start = 1'b1;
    word_count = 7'd1;
    push_byte(wd[23:16]);
    start = 1'b0;
    push_byte(wd[31:24]);
    send_word(32'h0000_00FF, 1'b0);
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    chk("final_wr_queue_empty", exp_wr.size(), 32'd0);
    chk("final_sum_queue_empty", exp_sum.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of instruction words in the target memory.
REQ-002 SHALL have parameter ADDR_W, default 6: word-address width (log2 DEPTH).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request a new load session; sampled in IDLE only.
REQ-006 SHALL have port word_count, input, ADDR_W+1: number of words to load, sampled with start.
REQ-007 SHALL have port byte_in, input, 8: incoming program byte.
REQ-008 SHALL have port byte_valid, input, 1: byte_in holds a valid byte.
REQ-009 SHALL have port byte_ready, output, 1: loader accepts a byte this cycle.
REQ-010 SHALL have port mem_we, output, 1: instruction-memory write strobe.
REQ-011 SHALL have port mem_addr, output, ADDR_W: instruction-memory word address.
REQ-012 SHALL have port mem_wdata, output, 32: instruction word to write.
REQ-013 SHALL have port busy, output, 1: high in LOAD and WRITE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse at end of a successful session.
REQ-015 SHALL have port error, output, 1: sticky flag for an illegal start; cleared by the next legal start or by reset.
REQ-016 SHALL have port checksum, output, 32: sum mod 2^32 of the words written this session.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, WRITE, DONE.
REQ-018 IDLE: start with 1<=word_count<=DEPTH SHALL go to LOAD, clearing word index, byte index, checksum and error.
REQ-019 IDLE: start with word_count==0 or >DEPTH SHALL set error, write nothing, and stay in IDLE.
REQ-020 byte_ready SHALL be 1 only in LOAD; a byte is accepted when byte_valid and byte_ready are both 1.
REQ-021 Bytes SHALL assemble little-endian: byte k of a word (k=0..3) goes to bits [8k+7:8k].
REQ-022 Acceptance of byte 3 SHALL move the FSM to WRITE on the next edge; byte_valid low in LOAD SHALL stall with no state change.
REQ-023 WRITE SHALL assert mem_we for exactly one cycle, with mem_addr = word index, mem_wdata = the assembled word, and byte_ready = 0.
REQ-024 In WRITE, checksum SHALL accumulate the word (wrap mod 2^32).
REQ-025 In WRITE, if word index == word_count-1 the FSM SHALL go to DONE; otherwise it SHALL increment the word index and return to LOAD.
REQ-026 Latency: mem_we SHALL rise exactly 1 cycle after the 4th byte handshake, so a back-to-back stream gives 5 cycles per word.
REQ-027 DONE SHALL assert done for one cycle, then return to IDLE; checksum SHALL hold until the next legal start.
REQ-028 start SHALL be ignored outside IDLE.
REQ-029 mem_addr and mem_wdata SHALL be 0 whenever mem_we is 0.
REQ-030 A word index reaching DEPTH-1 SHALL never wrap within a session; a full-depth load ends at address DEPTH-1.

Reset
REQ-031 reset SHALL force IDLE and clear byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error and checksum to 0 on the next edge.
REQ-032 A reset mid-session SHALL discard any partial word with no further writes; words already written are not recalled.
REQ-033 reset SHALL take priority over start and over byte handshakes in the same cycle.

Structure
REQ-034 A shared package SHALL hold the FSM state typedef, DEPTH/ADDR_W defaults and WORD_BYTES=4.
REQ-035 The byte-to-word assembler (shift register plus 2-bit byte counter) SHALL be one sub-module, word_assembler.
REQ-036 The block SHALL be a direct companion writer for the existing 64x32 instruction memory, with no memory inside the loader.

Verification
REQ-037 start, count=1; bytes 0x13,0x00,0x50,0x00 back-to-back -> one mem_we at addr 0 with wdata 0x00500013; done 1 cycle later; checksum 0x00500013.
REQ-038 count=3 with byte_valid low every other cycle -> writes to addr 0,1,2 in order; no byte lost or duplicated; busy high throughout.
REQ-039 count=0, then count=65 -> error=1, no mem_we, busy=0; next legal start clears error.
REQ-040 count=64 with all words 0xFFFFFFFF -> last write at addr 63; checksum 0xFFFFFFC0; done pulses once.
REQ-041 reset after 2 bytes of word 1 in a count=4 session -> all outputs 0, IDLE, no further mem_we; a new session starts cleanly at addr 0.
REQ-042 start pulsed during LOAD -> ignored; session completes with the original word_count.
